mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//   Memory-access stage directly downstream of the execute stage.
//   - Consumes the ALU address result, forwarded store data and write-back value.
//   - Performs word/half/byte loads and stores over a variable-latency req/gnt/rvalid data bus.
//   - Stalls upstream while a bus transaction is outstanding.
//   - Delivers aligned, extended load data (or the passed-through value) to write-back.
// PARAMETERS
//   ADDR_W   32   data-bus address width (address taken from in_addr[ADDR_W-1:0])
//   REG_W    5    destination register index width
// PORTS
//   clk          in   1       single clock, rising edge
//   reset        in   1       asynchronous, active-low reset
//   in_valid     in   1       EX result valid this cycle
//   in_ready     out  1       stage can accept (state==IDLE); EX must hold when low
//   in_op        in   4       memory op code (see package)
//   in_addr      in   32      effective address (EX ALU result)
//   in_wdata     in   32      store data (forwarded rt)
//   in_wd        in   32      write-back value for non-load ops
//   in_rd        in   REG_W   destination register
//   mem_req      out  1       bus request
//   mem_we       out  1       1=store
//   mem_addr     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//   mem_be       out  4       byte enables
//   mem_wdata    out  32      lane-shifted store data
//   mem_gnt      in   1       request accepted this cycle
//   mem_rvalid   in   1       load data valid
//   mem_rdata    in   32      load data (word)
//   out_valid    out  1       one-cycle result pulse to write-back
//   out_wd       out  32      load result or passed-through in_wd
//   out_rd       out  REG_W   destination register
//   out_exc      out  1       misaligned-access flag (MEM_ALIGN_CHECK_EN only, else 0)
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0 except in_ready=1; mem_req drops immediately (async).
//   - Ops: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8; 9..15 are treated as NONE.
//   - FSM states: IDLE, REQ, WAIT_R, RESP.
//   - IDLE, accept on in_valid:
//     - NONE: latch in_wd/in_rd, go to RESP (1-cycle latency).
//     - Memory op: latch address, op, data and rd; go to REQ.
//   - REQ: mem_req=1; address, we, be and wdata held stable until mem_gnt.
//     - On gnt, store: go to RESP.
//     - On gnt, load: go to WAIT_R.
//     - On gnt with rvalid in the same cycle (load): capture rdata, go to RESP.
//   - WAIT_R: on mem_rvalid, capture rdata, go to RESP. rvalid seen outside WAIT_R/REQ is ignored.
//   - RESP: out_valid=1 for exactly one cycle, then IDLE. in_ready=1 only in IDLE.
//   - Byte enables:
//     - SW: 4'b1111.
//     - SH: addr[1] ? 4'b1100 : 4'b0011.
//     - SB: 4'b0001<<addr[1:0].
//     - Loads: 4'b1111.
//   - Store data: SH replicates wdata[15:0] into both halves; SB replicates wdata[7:0] into all four lanes.
//   - Load extract: half = rdata[16*addr[1] +: 16], byte = rdata[8*addr[1:0] +: 8].
//     - LH/LB sign-extend; LHU/LBU zero-extend.
//   - Stores: out_wd = in_wd, latched at accept; out_rd = 0 (no write-back).
//   - Reset mid-transaction abandons it; the bus must tolerate a dropped request.
// CONFIGURATION
//   MEM_ALIGN_CHECK_EN defined:
//     - Misalignment: word op with addr[1:0]!=0, or half op with addr[0]!=0.
//     - Misaligned op skips REQ (no bus activity); goes IDLE->RESP with out_exc=1, out_rd=0.
//   MEM_ALIGN_CHECK_EN undefined:
//     - Offending low address bits ignored: word uses addr[1:0]=0, half uses addr[1].
//     - out_exc tied 0.
// STRUCTURE
//   - Shared package mem_pkg: op encoding constants, FSM state typedef, be/extend helper constants.
//   - Sub-module mem_load_ext: combinational; inputs op, addr[1:0], rdata; output extended 32-bit word.
//   - Top level holds the FSM, the latches and the store lane logic.
// TESTING
//   1 NONE op, in_wd=32'h1234_5678, rd=5 -> out_valid next cycle, out_wd=32'h1234_5678, out_rd=5, no mem_req.
//   2 SB addr=32'h0000_0103, wdata=32'h0000_00AB, gnt after 3 cycles -> mem_be=4'b1000, mem_wdata=32'hABAB_ABAB, addr=32'h100; in_ready low throughout.
//   3 LH addr=32'h202, gnt+rvalid same cycle, rdata=32'h8001_7FFF -> out_wd=32'hFFFF_8001; LHU on the same data -> 32'h0000_8001.
//   4 LB addr=32'h301, gnt, then rvalid 5 cycles later, rdata=32'h0000_9C00 -> out_wd=32'hFFFF_FF9C; exactly one out_valid pulse.
//   5 Reset asserted while in WAIT_R -> mem_req=0, out_valid=0, in_ready=1 immediately; a late rvalid does not produce output.
//   6 LW addr=32'h402: with MEM_ALIGN_CHECK_EN -> no mem_req, out_exc=1; without -> mem_addr=32'h400, normal load.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states,
// byte-enable constants and op-class helpers.
package mem_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE    = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_RESP
    } state_t;

    function automatic logic is_load(logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store(logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    function automatic logic is_word(logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data alignment and sign/zero extension of a returned bus word.
// Purely combinational; word loads ignore the low address bits.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ext
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = i_rdata[7:0];
        unique case (i_addr)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_ext = i_rdata;
        unique case (1'b1)
            (i_op == OP_LH):  o_ext = {{16{w_half[15]}}, w_half};
            (i_op == OP_LHU): o_ext = {16'h0000, w_half};
            (i_op == OP_LB):  o_ext = {{24{w_byte[7]}}, w_byte};
            (i_op == OP_LBU): o_ext = {24'h000000, w_byte};
            default:          o_ext = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: req/gnt/rvalid bus master with load/store lanes.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word/half accesses via out_exc.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [31:0]       in_wd,
    input  logic [REG_W-1:0]  in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       out_wd,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_exc
);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_wd;
    logic [REG_W-1:0]  r_rd;

    logic [3:0]  w_op;
    logic        w_mis;
    logic        w_accept;
    logic        w_capture;
    logic        w_req;
    logic        w_resp;
    logic [31:0] w_ext;
    logic [3:0]  w_be;
    logic [31:0] w_sdata;

    assign w_op     = (in_op > OP_SB) ? OP_NONE : in_op;
    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_req    = (r_state == S_REQ);
    assign w_resp   = (r_state == S_RESP);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_exc;

    assign w_mis = (is_word(w_op) && (in_addr[1:0] != 2'b00))
                 || (is_half(w_op) && in_addr[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_exc <= 1'b0;
        else if (w_accept) r_exc <= w_mis;
    end

    assign out_exc = w_resp && r_exc;
`else
    assign w_mis   = 1'b0;
    assign out_exc = 1'b0;
`endif

    // A load can complete in REQ when rvalid arrives together with gnt.
    assign w_capture = (w_req && mem_gnt && mem_rvalid && is_load(r_op))
                     || ((r_state == S_WAIT_R) && mem_rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid)
                    w_next = (is_load(w_op) || is_store(w_op)) && !w_mis
                           ? S_REQ : S_RESP;
            end
            S_REQ: begin
                if (mem_gnt)
                    w_next = (is_store(r_op) || mem_rvalid) ? S_RESP : S_WAIT_R;
            end
            S_WAIT_R: begin
                if (mem_rvalid) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= OP_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wd    <= '0;
            r_rd    <= '0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_addr  <= in_addr[ADDR_W-1:0];
            r_wdata <= in_wdata;
            r_wd    <= in_wd;
            r_rd    <= (is_store(w_op) || w_mis) ? '0 : in_rd;
        end else if (w_capture) begin
            r_wd    <= w_ext;
        end
    end

    mem_load_ext u_load_ext (
        .i_op    (r_op),
        .i_addr  (r_addr[1:0]),
        .i_rdata (mem_rdata),
        .o_ext   (w_ext)
    );

    always_comb begin
        w_be    = BE_WORD;
        w_sdata = r_wdata;
        unique case (1'b1)
            (r_op == OP_SH): begin
                w_be    = r_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                w_sdata = {2{r_wdata[15:0]}};
            end
            (r_op == OP_SB): begin
                w_be    = BE_BYTE << r_addr[1:0];
                w_sdata = {4{r_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Bus outputs are qualified by REQ so they fall with an async reset.
    assign mem_req   = w_req;
    assign mem_we    = w_req && is_store(r_op);
    assign mem_addr  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = w_req ? w_be : 4'b0000;
    assign mem_wdata = (w_req && is_store(r_op)) ? w_sdata : '0;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = w_resp;
    assign out_wd    = w_resp ? r_wd : '0;
    assign out_rd    = w_resp ? r_rd : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, reset corner
// cases and randomized transactions against an arithmetic reference model.
module tb_mem_access_stage;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          gd;
        int          rvd;
        logic [31:0] rdata;
        logic        bus;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] owd;
        logic [4:0]  ord;
        logic        exc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] in_wd;
    logic [4:0]  in_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_wd;
    logic [4:0]  out_rd;
    logic        out_exc;

    int n_vec;
    int n_err;

    mem_access_stage #(.ADDR_W(32), .REG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_wd      (in_wd),
        .in_rd      (in_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_wd     (out_wd),
        .out_rd     (out_rd),
        .out_exc    (out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t V(
        logic [3:0] op, logic [31:0] addr, logic [31:0] wdata,
        logic [31:0] wd, logic [4:0] rd, int gd, int rvd,
        logic [31:0] rdata, logic bus, logic [3:0] be,
        logic [31:0] maddr, logic [31:0] mwdata, logic [31:0] owd,
        logic [4:0] ord, logic exc);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.wd = wd;
        v.rd = rd; v.gd = gd; v.rvd = rvd; v.rdata = rdata;
        v.bus = bus; v.be = be; v.maddr = maddr; v.mwdata = mwdata;
        v.owd = owd; v.ord = ord; v.exc = exc;
        return v;
    endfunction

    // Reference: expected bus and result values from plain arithmetic.
    function automatic vec_t model(
        logic [3:0] op, logic [31:0] addr, logic [31:0] wdata,
        logic [31:0] wd, logic [4:0] rd, int gd, int rvd,
        logic [31:0] rdata);
        vec_t v;
        logic [31:0] lane;
        logic [31:0] hoff;
        logic [31:0] x;
        logic [3:0]  e;
        bit ld, st, mis;
        v = V(op, addr, wdata, wd, rd, gd, rvd, rdata,
              0, 4'hF, 32'h0, 32'h0, wd, rd, 0);
        e    = (op > 4'd8) ? 4'd0 : op;
        lane = addr % 32'd4;
        hoff = (lane / 32'd2) * 32'd2;
        ld   = (e >= 4'd1) && (e <= 4'd5);
        st   = (e >= 4'd6) && (e <= 4'd8);
        mis  = 0;
`ifdef MEM_ALIGN_CHECK_EN
        if ((e == 4'd1 || e == 4'd6) && lane != 0) mis = 1;
        if ((e == 4'd2 || e == 4'd3 || e == 4'd7) && (lane % 2) != 0) mis = 1;
`endif
        v.exc    = mis;
        v.bus    = (ld || st) && !mis;
        v.maddr  = addr - lane;
        v.mwdata = wdata;
        if (e == 4'd7) begin
            v.be     = 4'(32'd3 << hoff);
            v.mwdata = (wdata & 32'hFFFF) * 32'h0001_0001;
        end
        if (e == 4'd8) begin
            v.be     = 4'(32'd1 << lane);
            v.mwdata = (wdata & 32'hFF) * 32'h0101_0101;
        end
        if (st || mis) v.ord = 5'd0;
        if (ld && !mis) begin
            case (e)
                4'd1: v.owd = rdata;
                4'd2, 4'd3: begin
                    x = (rdata >> (8 * hoff)) & 32'hFFFF;
                    if (e == 4'd2 && x >= 32'h8000) x = x + 32'hFFFF_0000;
                    v.owd = x;
                end
                default: begin
                    x = (rdata >> (8 * lane)) & 32'hFF;
                    if (e == 4'd4 && x >= 32'h80) x = x + 32'hFFFF_FF00;
                    v.owd = x;
                end
            endcase
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        bit ld;
        ld = (v.op >= 4'd1) && (v.op <= 4'd5);
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1; in_op = v.op; in_addr = v.addr;
        in_wdata = v.wdata; in_wd = v.wd; in_rd = v.rd;
        @(negedge clk);
        in_valid = 0; in_op = 4'($urandom); in_addr = $urandom;
        in_wd = $urandom; in_rd = 5'($urandom);
        if (v.bus) begin
            for (int c = 0; c <= v.gd; c++) begin
                chk("req", mem_req, 1);
                chk("we", mem_we, ld ? 0 : 1);
                chk("addr", mem_addr, v.maddr);
                chk("be", mem_be, v.be);
                if (!ld) chk("wdata", mem_wdata, v.mwdata);
                chk("ready_busy", in_ready, 0);
                chk("no_out_req", out_valid, 0);
                if (c == v.gd) begin
                    mem_gnt = 1;
                    if (ld && v.rvd == 0) begin
                        mem_rvalid = 1; mem_rdata = v.rdata;
                    end
                end
                @(negedge clk);
            end
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (ld && v.rvd > 0) begin
                for (int c = 1; c < v.rvd; c++) begin
                    chk("wait_noreq", mem_req, 0);
                    chk("wait_ready", in_ready, 0);
                    chk("no_out_wait", out_valid, 0);
                    @(negedge clk);
                end
                mem_rvalid = 1; mem_rdata = v.rdata;
                @(negedge clk);
                mem_rvalid = 0; mem_rdata = $urandom;
            end
        end else begin
            chk("no_bus", mem_req, 0);
        end
        chk("out_valid", out_valid, 1);
        chk("out_wd", out_wd, v.owd);
        chk("out_rd", out_rd, v.ord);
        chk("out_exc", out_exc, v.exc);
        @(negedge clk);
        chk("pulse_end", out_valid, 0);
        chk("ready_back", in_ready, 1);
    endtask

    vec_t tbl[13];

    initial begin
        n_vec = 0; n_err = 0;
        reset = 0; in_valid = 0; in_op = 0; in_addr = 0; in_wdata = 0;
        in_wd = 0; in_rd = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        tbl[0]  = V(4'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 0, 0, 32'h0,
                    0, 4'hF, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 0);
        tbl[1]  = V(4'd8, 32'h0000_0103, 32'h0000_00AB, 32'hDEAD_0001, 5'd7,
                    3, 0, 32'h0, 1, 4'b1000, 32'h100, 32'hABAB_ABAB,
                    32'hDEAD_0001, 5'd0, 0);
        tbl[2]  = V(4'd2, 32'h202, 32'h0, 32'h0, 5'd9, 0, 0, 32'h8001_7FFF,
                    1, 4'hF, 32'h200, 32'h0, 32'hFFFF_8001, 5'd9, 0);
        tbl[3]  = V(4'd3, 32'h202, 32'h0, 32'h0, 5'd10, 1, 0, 32'h8001_7FFF,
                    1, 4'hF, 32'h200, 32'h0, 32'h0000_8001, 5'd10, 0);
        tbl[4]  = V(4'd4, 32'h301, 32'h0, 32'h0, 5'd11, 0, 5, 32'h0000_9C00,
                    1, 4'hF, 32'h300, 32'h0, 32'hFFFF_FF9C, 5'd11, 0);
`ifdef MEM_ALIGN_CHECK_EN
        tbl[5]  = V(4'd1, 32'h402, 32'h0, 32'h7777_0000, 5'd12, 0, 1,
                    32'h1122_3344, 0, 4'hF, 32'h400, 32'h0, 32'h7777_0000,
                    5'd0, 1);
        tbl[6]  = V(4'd7, 32'h205, 32'h0000_1234, 32'h6666_0000, 5'd13, 0, 0,
                    32'h0, 0, 4'hF, 32'h204, 32'h0, 32'h6666_0000, 5'd0, 1);
`else
        tbl[5]  = V(4'd1, 32'h402, 32'h0, 32'h7777_0000, 5'd12, 0, 1,
                    32'h1122_3344, 1, 4'hF, 32'h400, 32'h0, 32'h1122_3344,
                    5'd12, 0);
        tbl[6]  = V(4'd7, 32'h205, 32'h0000_1234, 32'h6666_0000, 5'd13, 0, 0,
                    32'h0, 1, 4'b0011, 32'h204, 32'h1234_1234,
                    32'h6666_0000, 5'd0, 0);
`endif
        tbl[7]  = V(4'd7, 32'h206, 32'h0000_BEEF, 32'h5, 5'd14, 1, 0, 32'h0,
                    1, 4'b1100, 32'h204, 32'hBEEF_BEEF, 32'h5, 5'd0, 0);
        tbl[8]  = V(4'd6, 32'h500, 32'hCAFE_F00D, 32'h6, 5'd15, 2, 0, 32'h0,
                    1, 4'hF, 32'h500, 32'hCAFE_F00D, 32'h6, 5'd0, 0);
        tbl[9]  = V(4'd5, 32'h302, 32'h0, 32'h0, 5'd16, 0, 2, 32'h00AB_0000,
                    1, 4'hF, 32'h300, 32'h0, 32'h0000_00AB, 5'd16, 0);
        tbl[10] = V(4'd12, 32'h302, 32'h0, 32'h0000_55AA, 5'd3, 0, 0, 32'h0,
                    0, 4'hF, 32'h0, 32'h0, 32'h0000_55AA, 5'd3, 0);
        tbl[11] = V(4'd4, 32'h300, 32'h0, 32'h0, 5'd17, 1, 1, 32'hFFFF_FF7F,
                    1, 4'hF, 32'h300, 32'h0, 32'h0000_007F, 5'd17, 0);
        tbl[12] = V(4'd8, 32'h0000_0102, 32'h1234_56CD, 32'h9, 5'd18, 0, 0,
                    32'h0, 1, 4'b0100, 32'h100, 32'hCDCD_CDCD, 32'h9, 5'd0, 0);

        #3;
        chk("rst_ready", in_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_wd", out_wd, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_exc", out_exc, 0);
        @(negedge clk);
        reset = 1;

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset while waiting for load data; a late rvalid must be ignored.
        @(negedge clk);
        in_valid = 1; in_op = 4'd4; in_addr = 32'h301; in_rd = 5'd4;
        @(negedge clk);
        in_valid = 0;
        chk("mid_req", mem_req, 1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        chk("mid_wait_busy", in_ready, 0);
        #2 reset = 0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        reset = 1;
        mem_rvalid = 1; mem_rdata = 32'h0000_9C00;
        @(negedge clk);
        mem_rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            chk("late_rvalid", out_valid, 0);
            chk("late_ready", in_ready, 1);
            @(negedge clk);
        end

        // Reset while requesting drops mem_req asynchronously.
        in_valid = 1; in_op = 4'd6; in_addr = 32'h40; in_wdata = 32'h1;
        @(negedge clk);
        in_valid = 0;
        chk("req_before_rst", mem_req, 1);
        #2 reset = 0;
        #1;
        chk("req_rst_drop", mem_req, 0);
        chk("req_rst_we", mem_we, 0);
        chk("req_rst_ready", in_ready, 1);
        @(negedge clk);
        reset = 1;

        for (int k = 0; k < 250; k++) begin
            vec_t v;
            logic [31:0] a;
            a = $urandom;
            if (($urandom % 2) == 0) a = a & 32'hFFFF_FFFC;
            v = model(4'($urandom_range(0, 15)), a, $urandom, $urandom,
                      5'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom);
            run_txn(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
